// File: rtl/uart_tx_arb.sv
//------------------------------------------------------------------------------
// uart_tx_arb
//
// Round-robin arbiter that shares one UART transmit channel between NUM_REQ
// byte sources. One byte is issued per UART frame. A requester keeps the grant
// across a multi-byte message until it flags the last byte, so messages never
// interleave on the line.
//
// Optional feature macro: UART_ARB_TIMEOUT_EN
//   defined   : a locked message that stalls for TIMEOUT_CYC cycles in HOLD is
//               abandoned, timeout_err pulses, and the lock is released.
//   undefined : HOLD waits indefinitely and timeout_err is tied low.
//
// Ports
//   clk, rst_n      : system clock, asynchronous active-low reset
//   req_valid[i]    : requester i has a byte
//   req_data        : byte of requester i at [i*PACK_SIZE +: PACK_SIZE]
//   req_last[i]     : the byte is the final byte of its message
//   req_ready[i]    : one-hot; byte i consumed on req_valid[i] & req_ready[i]
//   tx_byte_valid   : single-cycle pulse to the UART wrapper
//   tx_byte_data    : registered byte, stable from the pulse until tx_done
//   tx_active       : UART transmitter busy
//   tx_done         : one-cycle pulse at the end of the stop bit
//   grant_id        : current or last owner
//   busy            : high in every state except IDLE
//   timeout_err     : one-cycle pulse when a locked message times out
//------------------------------------------------------------------------------
module uart_tx_arb #(
   parameter int NUM_REQ     = 2,
   parameter int PACK_SIZE   = 8,
   parameter int TIMEOUT_CYC = 86800
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ*PACK_SIZE-1:0] req_data,
   input  logic [NUM_REQ-1:0]           req_last,
   output logic [NUM_REQ-1:0]           req_ready,
   output logic                         tx_byte_valid,
   output logic [PACK_SIZE-1:0]         tx_byte_data,
   input  logic                         tx_active,
   input  logic                         tx_done,
   output logic [$clog2(NUM_REQ)-1:0]   grant_id,
   output logic                         busy,
   output logic                         timeout_err
);

   localparam int          IDW = $clog2(NUM_REQ);
   localparam int unsigned NR  = NUM_REQ;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SEND = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_HOLD = 2'd3;

   logic [1:0]           state_q,  state_d;
   logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0]       owner_q,  owner_d;
   logic [PACK_SIZE-1:0] data_q,   data_d;
   logic                 last_q,   last_d;

   logic                 found;
   logic [IDW-1:0]       win;
   logic [IDW:0]         idx;
   logic                 hs;
   logic [IDW-1:0]       hs_id;
   logic [IDW-1:0]       next_ptr;
   logic [NUM_REQ-1:0]   ready_c;

   //---------------------------------------------------------------------------
   // Round-robin search: first valid requester at or above rr_ptr, with wrap.
   // idx carries one extra bit so rr_ptr + k can be folded back below NUM_REQ
   // without a general modulo, which also covers non power-of-two NUM_REQ.
   //---------------------------------------------------------------------------
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int unsigned k = 0; k < NR; k++) begin
         idx = {1'b0, rr_ptr_q} + (IDW+1)'(k);
         if (idx >= (IDW+1)'(NUM_REQ)) begin
            idx = idx - (IDW+1)'(NUM_REQ);
         end
         if (!found && req_valid[idx[IDW-1:0]]) begin
            found = 1'b1;
            win   = idx[IDW-1:0];
         end
      end
   end

   // Pointer advances past the owner once its message is finished.
   always_comb begin
      if (owner_q == IDW'(NUM_REQ-1)) begin
         next_ptr = '0;
      end else begin
         next_ptr = owner_q + IDW'(1);
      end
   end

`ifdef UART_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYC+1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          to_q,  to_d;

   // Counts stalled HOLD cycles; the count is cleared on the WAIT->HOLD move.
   always_comb begin
      cnt_d = cnt_q;
      to_d  = 1'b0;
      if (state_q == S_WAIT && tx_done && !last_q) begin
         cnt_d = '0;
      end else if (state_q == S_HOLD && !req_valid[owner_q]) begin
         if (cnt_q == CW'(TIMEOUT_CYC-1)) begin
            to_d  = 1'b1;
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         to_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         to_q  <= to_d;
      end
   end

   assign timeout_err = to_q;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
   assign timeout_err        = 1'b0;
`endif

   //---------------------------------------------------------------------------
   // Next-state logic. hs marks the single handshake cycle; data, last and
   // owner are captured only then, so requesters may change them afterwards.
   //---------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      owner_d  = owner_q;
      data_d   = data_q;
      last_d   = last_q;
      hs       = 1'b0;
      hs_id    = owner_q;

      case (state_q)
         S_IDLE: begin
            if (found && !tx_active) begin
               hs      = 1'b1;
               hs_id   = win;
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            // tx_done coinciding with the pulse belongs to an older frame.
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (tx_done) begin
               if (last_q) begin
                  rr_ptr_d = next_ptr;
                  state_d  = S_IDLE;
               end else begin
                  state_d  = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (req_valid[owner_q]) begin
               hs      = 1'b1;
               hs_id   = owner_q;
               state_d = S_SEND;
            end
`ifdef UART_ARB_TIMEOUT_EN
            else if (to_d) begin
               rr_ptr_d = next_ptr;
               state_d  = S_IDLE;
            end
`endif
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (hs) begin
         owner_d = hs_id;
         data_d  = req_data[int'(hs_id)*PACK_SIZE +: PACK_SIZE];
         last_d  = req_last[hs_id];
      end
   end

   always_comb begin
      ready_c        = '0;
      ready_c[hs_id] = hs;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         rr_ptr_q <= '0;
         owner_q  <= '0;
         data_q   <= '0;
         last_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q  <= owner_d;
         data_q   <= data_d;
         last_q   <= last_d;
      end
   end

   // req_ready is combinational from IDLE; gate it so reset forces it low
   // even while a requester is holding req_valid.
   assign req_ready     = rst_n ? ready_c : '0;
   assign tx_byte_valid = (state_q == S_SEND);
   assign tx_byte_data  = data_q;
   assign grant_id      = owner_q;
   assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arb.sv
module tb_uart_tx_arb;

   localparam int NR    = 2;
   localparam int PW    = 8;
   localparam int TO    = 20;
   localparam int FRAME = 10;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [NR-1:0] req_valid;
   logic [NR*PW-1:0] req_data;
   logic [NR-1:0] req_last;
   logic [NR-1:0] req_ready;
   logic          tx_byte_valid;
   logic [PW-1:0] tx_byte_data;
   logic          tx_active;
   logic          tx_done;
   logic [0:0]    grant_id;
   logic          busy;
   logic          timeout_err;

   logic uart_busy;
   logic force_active;
   assign tx_active = uart_busy | force_active;

   uart_tx_arb #(.NUM_REQ(NR), .PACK_SIZE(PW), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
      .req_ready(req_ready),
      .tx_byte_valid(tx_byte_valid), .tx_byte_data(tx_byte_data),
      .tx_active(tx_active), .tx_done(tx_done),
      .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
   );

   initial forever #5 clk = ~clk;

   typedef struct packed { logic [7:0] data; logic last; } item_t;
   typedef struct packed { logic [0:0] id; logic [7:0] data; } exp_t;

   item_t rq0[$];
   item_t rq1[$];
   exp_t  expq[$];

   int nvec = 0;
   int nfail = 0;
   int cyc = 0;
   int done_cyc[$];
   int rdy1_cyc = -1;
   bit to_seen = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Requesters: present the head of each queue, pop it after a handshake.
   initial begin
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      forever begin
         logic [NR-1:0] hs;
         @(negedge clk);
         hs = req_valid & req_ready;
         @(posedge clk);
         #1;
         if (hs[0] && rq0.size() > 0) void'(rq0.pop_front());
         if (hs[1] && rq1.size() > 0) void'(rq1.pop_front());
         req_valid[0] = (rq0.size() > 0);
         req_valid[1] = (rq1.size() > 0);
         if (rq0.size() > 0) begin req_data[7:0]  = rq0[0].data; req_last[0] = rq0[0].last; end
         if (rq1.size() > 0) begin req_data[15:8] = rq1[0].data; req_last[1] = rq1[0].last; end
      end
   end

   // UART model: busy for FRAME cycles after each pulse, then tx_done.
   initial begin
      uart_busy = 1'b0;
      tx_done   = 1'b0;
      forever begin
         @(negedge clk);
         if (tx_byte_valid) begin
            @(posedge clk); #1 uart_busy = 1'b1;
            repeat (FRAME) @(posedge clk);
            #1 tx_done = 1'b1;
            @(posedge clk); #1;
            tx_done   = 1'b0;
            uart_busy = 1'b0;
         end
      end
   end

   // Scoreboard monitor: every byte put on the line is checked in order.
   initial forever begin
      @(negedge clk);
      if (tx_byte_valid) begin
         if (expq.size() == 0) begin
            nvec++;
            nfail++;
            $display("FAIL line_unexpected: got byte %0h id %0d expected none", tx_byte_data, grant_id);
         end else begin
            exp_t e;
            e = expq.pop_front();
            check("line_data", {24'd0, tx_byte_data}, {24'd0, e.data});
            check("line_id", {31'd0, grant_id}, {31'd0, e.id});
         end
      end
      if (tx_done) done_cyc.push_back(cyc);
      if (req_ready[1] && rdy1_cyc < 0) rdy1_cyc = cyc;
      if (timeout_err) to_seen = 1'b1;
   end

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      done_cyc.delete();
      rdy1_cyc = -1;
      to_seen  = 1'b0;
   endtask

   task automatic drain(input string name, input int budget);
      int n = 0;
      while ((expq.size() != 0 || busy || uart_busy || rq0.size() != 0 || rq1.size() != 0) && n < budget) begin
         @(posedge clk);
         n++;
      end
      check({"drain_", name}, {31'd0, (n < budget)}, 32'd1);
      repeat (2) @(posedge clk);
   endtask

   task automatic wait_valid(input int idx, input string name);
      int n = 0;
      @(negedge clk);
      while (!req_valid[idx] && n < 20) begin @(negedge clk); n++; end
      check({"wait_", name}, {31'd0, (n < 20)}, 32'd1);
   endtask

   initial begin
      int n;
      int t_done;
      force_active = 1'b0;

      // ---- Test 1: reset state, single byte, rr pointer moves to 1 ----
      rst_n = 1'b0;
      @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_outs", {19'd0, req_ready, tx_byte_valid, tx_byte_data, grant_id, timeout_err}, 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      expq.push_back('{id: 1'b0, data: 8'h41});
      rq0.push_back('{data: 8'h41, last: 1'b1});
      wait_valid(0, "t1_valid");
      check("t1_ready_same_cycle", {30'd0, req_ready}, 32'd1);
      @(negedge clk);
      check("t1_pulse_next", {31'd0, tx_byte_valid}, 32'd1);
      n = 0;
      while (!tx_done && n < 40) begin @(negedge clk); n++; end
      @(negedge clk);
      check("t1_busy_after_done", {31'd0, busy}, 32'd0);
      // Pointer now at 1: with both requesting, req1 must win first.
      expq.push_back('{id: 1'b1, data: 8'h43});
      expq.push_back('{id: 1'b0, data: 8'h42});
      rq0.push_back('{data: 8'h42, last: 1'b1});
      rq1.push_back('{data: 8'h43, last: 1'b1});
      drain("t1", 200);

      // ---- Test 2: both continuously valid, round-robin alternation ----
      do_reset();
      for (int i = 0; i < 2; i++) begin
         rq0.push_back('{data: 8'h10, last: 1'b1});
         rq1.push_back('{data: 8'h20, last: 1'b1});
         expq.push_back('{id: 1'b0, data: 8'h10});
         expq.push_back('{id: 1'b1, data: 8'h20});
      end
      drain("t2", 300);

      // ---- Test 3: locked 3-byte message from req0, req1 waits ----
      do_reset();
      rq0.push_back('{data: 8'hA1, last: 1'b0});
      rq0.push_back('{data: 8'hA2, last: 1'b0});
      rq0.push_back('{data: 8'hA3, last: 1'b1});
      rq1.push_back('{data: 8'hB1, last: 1'b1});
      expq.push_back('{id: 1'b0, data: 8'hA1});
      expq.push_back('{id: 1'b0, data: 8'hA2});
      expq.push_back('{id: 1'b0, data: 8'hA3});
      expq.push_back('{id: 1'b1, data: 8'hB1});
      drain("t3", 300);
      t_done = (done_cyc.size() >= 3) ? done_cyc[2] : -100;
      check("t3_ready1_after_a3", rdy1_cyc, t_done + 1);
      check("t3_no_timeout", {31'd0, to_seen}, 32'd0);

      // ---- Test 4: tx_active blocks the IDLE handshake ----
      do_reset();
      force_active = 1'b1;
      rq1.push_back('{data: 8'h55, last: 1'b1});
      expq.push_back('{id: 1'b1, data: 8'h55});
      wait_valid(1, "t4_valid");
      for (int k = 0; k < 4; k++) begin
         check("t4_stall", {30'd0, req_ready}, 32'd0);
         @(negedge clk);
      end
      @(posedge clk); #1 force_active = 1'b0;
      @(negedge clk);
      check("t4_ready_after_fall", {30'd0, req_ready}, 32'd2);
      drain("t4", 200);

      // ---- Test 5: stalled locked message ----
      do_reset();
      rq0.push_back('{data: 8'hC1, last: 1'b0});
      rq1.push_back('{data: 8'hD1, last: 1'b1});
      expq.push_back('{id: 1'b0, data: 8'hC1});
      n = 0;
      @(negedge clk);
      while (!tx_done && n < 60) begin @(negedge clk); n++; end
      t_done = cyc;
`ifdef UART_ARB_TIMEOUT_EN
      expq.push_back('{id: 1'b1, data: 8'hD1});
      n = 0;
      while (!timeout_err && n < 60) begin @(negedge clk); n++; end
      check("t5_timeout_delay", cyc - t_done, 32'd21);
      drain("t5", 200);
      check("t5_timeout_seen", {31'd0, to_seen}, 32'd1);
`else
      repeat (40) @(negedge clk);
      check("t5_hold_busy", {31'd0, busy}, 32'd1);
      check("t5_hold_owner", {31'd0, grant_id}, 32'd0);
      check("t5_hold_stall", {30'd0, req_ready}, 32'd0);
      check("t5_no_timeout", {31'd0, to_seen}, 32'd0);
      expq.push_back('{id: 1'b0, data: 8'hC2});
      expq.push_back('{id: 1'b1, data: 8'hD1});
      rq0.push_back('{data: 8'hC2, last: 1'b1});
      drain("t5", 300);
`endif

      // ---- Test 6: reset during WAIT_DONE of a locked message ----
      do_reset();
      rq0.push_back('{data: 8'hE1, last: 1'b0});
      rq1.push_back('{data: 8'hD2, last: 1'b1});
      expq.push_back('{id: 1'b0, data: 8'hE1});
      expq.push_back('{id: 1'b1, data: 8'hD2});
      n = 0;
      @(negedge clk);
      while (!tx_byte_valid && n < 20) begin @(negedge clk); n++; end
      @(posedge clk); #3 rst_n = 1'b0;
      #1;
      check("t6_async_busy", {31'd0, busy}, 32'd0);
      check("t6_async_data", {24'd0, tx_byte_data}, 32'd0);
      check("t6_async_outs", {28'd0, req_ready, tx_byte_valid, grant_id}, 32'd0);
      @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
      drain("t6", 200);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin arbiter sharing a single `uart_tx_rx` transmit channel between `NUM_REQ` byte sources, such as the rx echo path and a status/telemetry reporter. It grants one requester at a time and issues one byte per UART frame. A requester keeps the grant for a multi-byte message until it marks the last byte, so messages never interleave on the line. It sits between the requesters and the `tx_byte_valid`/`tx_byte_data`/`tx_done` ports of the UART wrapper.

## Interface
- `NUM_REQ`, 2: number of requesters (2..8).
- `PACK_SIZE`, 8: bits per UART byte.
- `TIMEOUT_CYC`, 86800: idle cycles allowed inside a locked message (only with `UART_ARB_TIMEOUT_EN`).
- `clk` input 1: system clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input `NUM_REQ`: requester i has a byte.
- `req_data` input `NUM_REQ*PACK_SIZE`: byte for requester i at bits `[i*PACK_SIZE +: PACK_SIZE]`.
- `req_last` input `NUM_REQ`: byte is the final byte of its message.
- `req_ready` output `NUM_REQ`: one-hot; byte i is consumed when `req_valid[i] & req_ready[i]`.
- `tx_byte_valid` output 1: single-cycle pulse to the UART wrapper.
- `tx_byte_data` output `PACK_SIZE`: registered byte, stable from the pulse until `tx_done`.
- `tx_active` input 1: transmitter busy.
- `tx_done` input 1: one-cycle pulse at the end of the stop bit.
- `grant_id` output `$clog2(NUM_REQ)`: current or last owner.
- `busy` output 1: high in every state except IDLE.
- `timeout_err` output 1: one-cycle pulse on a lock timeout (0 when the macro is off).

## Operation
- States: IDLE, SEND, WAIT_DONE, HOLD.
- **IDLE**
  - Selects the first requester with `req_valid` set, searching from `rr_ptr` upward with wrap.
  - Asserts `req_ready[winner]` combinationally and captures the winner's data, `req_last`, and id.
  - Goes to SEND only if `tx_active` is 0. While `tx_active` is 1, `req_ready` stays 0.
- **SEND** (exactly 1 cycle): `tx_byte_valid` = 1; then goes to WAIT_DONE.
- **WAIT_DONE**: waits for `tx_done`.
  - If the captured last flag is 1: `rr_ptr` becomes `(owner+1) mod NUM_REQ` and the state goes to IDLE.
  - Otherwise the state goes to HOLD.
- **HOLD**: only the owner is eligible.
  - When `req_valid[owner]` is set: `req_ready[owner]` = 1, the new byte is captured, and the state goes to SEND.
  - Other requesters stall regardless of their `req_valid`.
- `req_ready` is never asserted to more than one requester and is never asserted in SEND or WAIT_DONE.
- `req_data`/`req_last` are sampled only on the handshake cycle; the requester may change them afterwards.
- `tx_done` outside WAIT_DONE is ignored. `tx_done` in the same cycle as the SEND pulse is ignored; WAIT_DONE begins the following cycle.
- Reset in any state takes effect immediately:
  - state = IDLE, `rr_ptr` = 0.
  - All outputs 0: `req_ready`, `tx_byte_valid`, `tx_byte_data`, `grant_id`, `busy`, `timeout_err`.
  - A byte already handed to the UART is not recalled.

## Timing
- Handshake in IDLE at cycle N gives `tx_byte_valid` at N+1. `grant_id` and `tx_byte_data` update at N+1.
- `tx_done` at cycle M gives:
  - IDLE at M+1; a new handshake is possible at M+1 with its pulse at M+2.
  - HOLD at M+1; if the owner is valid, handshake at M+1 and pulse at M+2.
- Byte-to-byte gap on the line is therefore 2 cycles beyond the UART frame time.
- Round-robin fairness: with all requesters continuously valid and single-byte messages, grants rotate 0,1,…,`NUM_REQ`-1,0.

## Configuration
- `UART_ARB_TIMEOUT_EN` defined:
  - A counter clears on entry to HOLD and increments each HOLD cycle while `req_valid[owner]` is 0.
  - On reaching `TIMEOUT_CYC`: `timeout_err` pulses for 1 cycle, `rr_ptr` becomes owner+1, and the state goes to IDLE (the lock is released).
- `UART_ARB_TIMEOUT_EN` undefined: no counter logic, `timeout_err` tied to 0, and HOLD waits indefinitely.

## Test plan
- Reset with `rst_n`=0, then release; only `req_valid[0]` is set, data 0x41, last=1.
  - Required: `req_ready[0]` the same cycle, `tx_byte_valid` pulse with `tx_byte_data`=0x41 one cycle later, `grant_id`=0.
  - After `tx_done`: `busy`=0 and `rr_ptr`=1.
- Both requesters continuously valid (req0 0x10, req1 0x20), all last=1, 4 frames.
  - Required: UART sequence 0x10, 0x20, 0x10, 0x20.
- Req0 sends a 3-byte message 0xA1, 0xA2, 0xA3 (last on 0xA3) while req1 holds 0xB1 valid throughout.
  - Required: line order 0xA1, 0xA2, 0xA3, 0xB1.
  - `req_ready[1]` stays 0 until IDLE follows 0xA3's `tx_done`.
- `tx_active` held at 1 with `req_valid[1]` set.
  - Required: no `req_ready`; the handshake occurs in the first cycle after `tx_active` falls.
- Macro on, `TIMEOUT_CYC`=20: req0 sends 0xC1 with last=0, then drops valid.
  - Required: `timeout_err` pulses 20 cycles after HOLD entry; a pending req1 byte 0xD1 is then granted.
- `rst_n` asserted during WAIT_DONE of a locked message.
  - Required: outputs 0 asynchronously; after release, req1 can win in IDLE without waiting on the old owner.
